dma_burst_sequencer: RTL and testbench

- Splits one configured DMA block transfer (bus memory <-> 512-word local SSRAM) into bus bursts and sequences them.
- Owns the bus request/grant handshake and issues one burst command at a time to the DMA bus engine, advancing bus and SSRAM addresses.
- Sits between the custom-instruction configuration registers and the DMA bus-transaction engine; reports busy/done/error back to the CPU.

---
 rtl/dma_burst_sequencer.sv | 177 +++++++++++++++++
 tb/tb_dma_burst_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer: splits one DMA block transfer between bus memory and
// the local SSRAM into bus bursts, owns the bus request/grant handshake and
// issues one burst command at a time to the DMA bus engine.
//
// Ports
//   clock, reset            system clock, async active-low reset
//   start, dir_rnw, cfg_*   transfer launch pulse and configuration
//   busRequest/grantRequest bus arbitration handshake
//   burst_*                 burst command to the bus engine (start pulse,
//                           direction, addresses, length-1)
//   burst_done/burst_error  burst completion status from the engine
//   busy, done, error       transfer status to the CPU (error is sticky)
//   words_left              words not yet transferred
module dma_burst_sequencer #(
  parameter int unsigned MEM_ADDR_W = 9,
  parameter bit          HOLD_BUS   = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dir_rnw,
  input  logic [31:0]           cfg_bus_addr,
  input  logic [MEM_ADDR_W-1:0] cfg_mem_addr,
  input  logic [9:0]            cfg_block_size,
  input  logic [7:0]            cfg_burst_size,
  output logic                  busRequest,
  input  logic                  grantRequest,
  output logic                  burst_start,
  output logic                  burst_rnw,
  output logic [31:0]           burst_bus_addr,
  output logic [MEM_ADDR_W-1:0] burst_mem_addr,
  output logic [7:0]            burst_len,
  input  logic                  burst_done,
  input  logic                  burst_error,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [9:0]            words_left
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BLK_W  = 10;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                  rnw_q;
  logic [ADDR_W-1:0]     bus_addr_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [LEN_W-1:0]      burst_cfg_q;
  logic [BLK_W-1:0]      words_left_q;
  logic [LEN_W-1:0]      len_m1_q;
  logic                  error_q;

  logic                  bus_request_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  burst_start_d;

  logic [BLK_W-1:0]      span_c;
  logic [LEN_W-1:0]      len_m1_c;
  logic [CNT_W-1:0]      len_c;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && (cfg_block_size != '0)) state_d = S_REQ;
      S_REQ:   if (grantRequest) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      // error wins when both status pulses arrive together
      S_WAIT:  begin
        if (burst_error)     state_d = S_IDLE;
        else if (burst_done) state_d = S_NEXT;
      end
      // words_left was already decremented on entry to NEXT
      S_NEXT:  state_d = (words_left_q == '0) ? S_IDLE : S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs for the coming cycle, decoded from the next state
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    burst_start_d = (state_d == S_ISSUE);
    bus_request_d = (state_d == S_REQ) || (state_d == S_ISSUE) ||
                    (state_d == S_WAIT) || ((state_d == S_NEXT) && HOLD_BUS);
    done_d        = ((state_q == S_IDLE) && start && (cfg_block_size == '0)) ||
                    ((state_q == S_NEXT) && (state_d == S_IDLE));
  end

  // Burst length: min(words_left, burst_size + 1), kept as length - 1
  always_comb begin
    span_c = BLK_W'(burst_cfg_q) + BLK_W'(1);
    if (words_left_q >= span_c) begin
      len_m1_c = burst_cfg_q;
    end else begin
      len_m1_c = LEN_W'(words_left_q - BLK_W'(1));
    end
    len_c = CNT_W'(len_m1_q) + CNT_W'(1);
  end

  // Registered control outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busRequest  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      burst_start <= 1'b0;
    end else begin
      busRequest  <= bus_request_d;
      busy        <= busy_d;
      done        <= done_d;
      burst_start <= burst_start_d;
    end
  end

  // Configuration latch, address/count advance and sticky error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rnw_q        <= 1'b0;
      bus_addr_q   <= '0;
      mem_addr_q   <= '0;
      burst_cfg_q  <= '0;
      words_left_q <= '0;
      len_m1_q     <= '0;
      error_q      <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        rnw_q        <= dir_rnw;
        bus_addr_q   <= cfg_bus_addr & ~ADDR_W'(3);
        mem_addr_q   <= cfg_mem_addr;
        burst_cfg_q  <= cfg_burst_size;
        words_left_q <= cfg_block_size;
        error_q      <= 1'b0;
      end
      if (state_q == S_REQ) begin
        len_m1_q <= len_m1_c;
      end
      if (state_q == S_WAIT) begin
        if (burst_error) begin
          error_q <= 1'b1;
        end else if (burst_done) begin
          words_left_q <= words_left_q - BLK_W'(len_c);
          bus_addr_q   <= bus_addr_q + ADDR_W'({len_c, 2'b00});
          mem_addr_q   <= mem_addr_q + MEM_ADDR_W'(len_c);
        end
      end
    end
  end

  assign burst_rnw      = rnw_q;
  assign burst_bus_addr = bus_addr_q;
  assign burst_mem_addr = mem_addr_q;
  assign burst_len      = len_m1_q;
  assign words_left     = words_left_q;
  assign error          = error_q;

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Self-checking bench for dma_burst_sequencer: a reference model expands each
// transfer into its list of expected bursts; monitors compare every burst
// command and done pulse the DUT presents against the queued expectations.
module tb_dma_burst_sequencer;

  localparam int unsigned MEM_W = 9;

  typedef struct {
    logic [31:0]      ba;
    logic [MEM_W-1:0] ma;
    logic [7:0]       len;
    logic             rnw;
    logic [9:0]       wl;
  } burst_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             dir_rnw;
  logic [31:0]      cfg_bus_addr;
  logic [MEM_W-1:0] cfg_mem_addr;
  logic [9:0]       cfg_block_size;
  logic [7:0]       cfg_burst_size;
  logic             busRequest;
  logic             grantRequest;
  logic             burst_start;
  logic             burst_rnw;
  logic [31:0]      burst_bus_addr;
  logic [MEM_W-1:0] burst_mem_addr;
  logic [7:0]       burst_len;
  logic             burst_done;
  logic             burst_error;
  logic             busy;
  logic             done;
  logic             error;
  logic [9:0]       words_left;

  dma_burst_sequencer #(.MEM_ADDR_W(MEM_W), .HOLD_BUS(1'b0)) dut (
    .clock(clock), .reset(reset), .start(start), .dir_rnw(dir_rnw),
    .cfg_bus_addr(cfg_bus_addr), .cfg_mem_addr(cfg_mem_addr),
    .cfg_block_size(cfg_block_size), .cfg_burst_size(cfg_burst_size),
    .busRequest(busRequest), .grantRequest(grantRequest),
    .burst_start(burst_start), .burst_rnw(burst_rnw),
    .burst_bus_addr(burst_bus_addr), .burst_mem_addr(burst_mem_addr),
    .burst_len(burst_len), .burst_done(burst_done), .burst_error(burst_error),
    .busy(busy), .done(done), .error(error), .words_left(words_left)
  );

  always #5 clock = ~clock;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  burst_t exp_q[$];
  int     exp_done_cnt = 0;
  int     exp_done_cyc = -100;

  // bus arbiter / engine knobs
  int grant_delay = 0;
  int burst_lat   = 1;
  int err_at      = -1;
  int eng_idx     = 0;
  int eng_cnt     = 0;
  int req_cnt     = 0;
  bit inject_spur = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Arbiter: grant after grant_delay cycles of continuous request
  always @(negedge clock) begin
    if (!reset || !busRequest) begin
      req_cnt      = 0;
      grantRequest = 1'b0;
    end else begin
      grantRequest = (req_cnt >= grant_delay);
      req_cnt++;
    end
  end

  // Bus engine: answers each burst after burst_lat cycles, erroring on err_at
  always @(negedge clock) begin
    burst_done  = 1'b0;
    burst_error = 1'b0;
    if (!reset) begin
      eng_cnt = 0;
    end else begin
      if (inject_spur) begin
        burst_done  = 1'b1;
        inject_spur = 1'b0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          if (eng_idx == err_at) begin
            burst_error = 1'b1;
          end else begin
            burst_done   = 1'b1;
            exp_done_cyc = cyc + 2;
          end
          eng_idx++;
        end
      end
      if (burst_start) eng_cnt = burst_lat;
    end
  end

  // Burst command monitor
  always @(negedge clock) begin
    if (reset && burst_start) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL burst_unexpected: got burst at 0x%0h expected none", burst_bus_addr);
      end else begin
        burst_t e;
        e = exp_q.pop_front();
        check("burst_bus_addr", burst_bus_addr, e.ba);
        check("burst_mem_addr", 32'(burst_mem_addr), 32'(e.ma));
        check("burst_len", 32'(burst_len), 32'(e.len));
        check("burst_rnw", 32'(burst_rnw), 32'(e.rnw));
        check("burst_words_left", 32'(words_left), 32'(e.wl));
      end
    end
  end

  // Done pulse monitor
  always @(negedge clock) begin
    if (reset && done) begin
      check("done_expected", 32'(exp_done_cnt > 0), 32'd1);
      if (exp_done_cnt > 0) exp_done_cnt--;
      check("done_latency", 32'(cyc), 32'(exp_done_cyc));
    end
  end

  task automatic run_xfer(input logic [31:0] bus, input int unsigned mem,
                          input int unsigned block, input int unsigned burst,
                          input bit rnw, input int gd, input int ea, input int lat,
                          input bit poke, input bit spur);
    int unsigned rem, len, idx, req_cycles;
    logic [31:0] b;
    logic [MEM_W-1:0] m;
    bit err_hit, fin, first, saw_req;
    burst_t e;
    // reference model: expand transfer into burst list
    rem = block; b = bus & 32'hFFFF_FFFC; m = MEM_W'(mem); idx = 0; err_hit = 0;
    while (rem > 0) begin
      len = (rem < burst + 1) ? rem : burst + 1;
      e.ba = b; e.ma = m; e.len = 8'(len - 1); e.rnw = rnw; e.wl = 10'(rem);
      exp_q.push_back(e);
      if (int'(idx) == ea) begin err_hit = 1; break; end
      rem -= len;
      b   += 32'(len * 4);
      m    = MEM_W'(32'(m) + len);
      idx++;
    end
    if (!err_hit) exp_done_cnt++;
    grant_delay = gd; burst_lat = lat; err_at = ea; eng_idx = 0;

    @(negedge clock);
    cfg_bus_addr = bus; cfg_mem_addr = MEM_W'(mem); cfg_block_size = 10'(block);
    cfg_burst_size = 8'(burst); dir_rnw = rnw; start = 1'b1;
    if (block == 0) exp_done_cyc = cyc + 1;
    fin = 0; first = 1; saw_req = 0; req_cycles = 0;
    for (int t = 0; t < 4000 && !fin; t++) begin
      @(negedge clock);
      start = poke && (t == 0);
      if (poke && t == 0) begin
        cfg_bus_addr   = ~bus;
        cfg_mem_addr   = MEM_W'(mem + 3);
        cfg_block_size = 10'(block + 5);
        cfg_burst_size = 8'(burst) ^ 8'h01;
        dir_rnw        = ~rnw;
      end
      if (spur && t == 1) inject_spur = 1'b1;
      if (busRequest) saw_req = 1;
      if (burst_start) first = 0;
      else if (first && busRequest) req_cycles++;
      if (done || (error && !busy)) fin = 1;
    end
    check("xfer_finished", 32'(fin), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_busRequest", 32'(busRequest), 32'd0);
    check("end_error", 32'(error), 32'(err_hit));
    check("end_words_left", 32'(words_left), rem);
    if (block == 0) begin
      check("zero_block_no_request", 32'(saw_req), 32'd0);
    end else begin
      check("grant_wait_cycles", req_cycles, 32'(gd + 1));
    end
    @(negedge clock);
    check("bursts_outstanding", 32'(exp_q.size()), 32'd0);
    check("done_outstanding", 32'(exp_done_cnt), 32'd0);
  endtask

  task automatic reset_in_wait();
    burst_t e;
    bit seen;
    e.ba = 32'h0000_4000; e.ma = '0; e.len = 8'd31; e.rnw = 1'b1; e.wl = 10'd64;
    exp_q.push_back(e);
    grant_delay = 0; burst_lat = 50; err_at = -1; eng_idx = 0;
    @(negedge clock);
    cfg_bus_addr = 32'h0000_4000; cfg_mem_addr = '0; cfg_block_size = 10'd64;
    cfg_burst_size = 8'd31; dir_rnw = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (burst_start) seen = 1;
      else @(negedge clock);
    end
    check("reset_test_burst_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clock);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_busRequest", 32'(busRequest), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_burst_bus_addr", burst_bus_addr, 32'd0);
    check("rst_burst_len", 32'(burst_len), 32'd0);
    check("rst_words_left", 32'(words_left), 32'd0);
    check("rst_done_error", 32'({done, error, burst_start}), 32'd0);
    exp_q.delete();
    exp_done_cnt = 0;
    @(negedge clock);
    reset = 1'b1;
    repeat (60) @(negedge clock);
    check("post_reset_idle", 32'({busy, busRequest, error}), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dir_rnw = 1'b0; cfg_bus_addr = '0;
    cfg_mem_addr = '0; cfg_block_size = '0; cfg_burst_size = '0;
    repeat (3) @(negedge clock);
    check("reset_busRequest", 32'(busRequest), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_burst_start", 32'(burst_start), 32'd0);
    check("reset_words_left", 32'(words_left), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run_xfer(32'h0000_1000, 0,   16, 7,   1'b1, 0, -1, 2, 1'b0, 1'b0);
    run_xfer(32'h0000_2003, 508, 10, 3,   1'b0, 0, -1, 1, 1'b0, 1'b0);
    run_xfer(32'h0000_3000, 5,   0,  7,   1'b1, 0, -1, 1, 1'b0, 1'b0);
    run_xfer(32'h0000_8000, 100, 20, 255, 1'b1, 5, -1, 3, 1'b0, 1'b1);
    run_xfer(32'h0001_0000, 40,  12, 3,   1'b0, 1, 1,  2, 1'b0, 1'b0);
    run_xfer(32'hFFFF_FFF0, 500, 24, 7,   1'b1, 2, -1, 1, 1'b1, 1'b0);
    reset_in_wait();

    for (int r = 0; r < 12; r++) begin
      int unsigned blk, bst, nb;
      int ea;
      blk = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 60);
      case ($urandom_range(0, 3))
        0:       bst = 0;
        1:       bst = 255;
        default: bst = $urandom_range(1, 15);
      endcase
      nb = (blk + bst) / (bst + 1);
      ea = (blk > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      run_xfer($urandom, $urandom_range(0, 511), blk, bst, 1'($urandom),
               int'($urandom_range(0, 3)), ea, int'($urandom_range(1, 4)),
               1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
